// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the default operand width.
// The encoding values are fixed so that sibling serial blocks decode states identically.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a, b  - minuend and subtrahend bits
//   bin   - incoming borrow
//   d     - difference bit
//   bout  - outgoing borrow
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles with one registered borrow.
// Latency: accept edge 0, SHIFT on edges 1..WIDTH, done pulse in the cycle after edge WIDTH.
// Backpressure: none; start is only honoured in IDLE, requests in SHIFT/DONE are dropped.
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset
//   start            - operation request, sampled only in IDLE
//   a, b             - minuend and subtrahend, captured on the accepting edge
//   busy             - high while shifting
//   done             - one-cycle pulse; diff/borrow_out valid
//   diff, borrow_out - result modulo 2^WIDTH and final borrow (1 iff a < b)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] w_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             bit_d;
    logic             bit_bo;
    logic             last_bit;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_bo)
    );

    assign last_bit = (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    // Datapath. The working register collects difference bits from the top down,
    // so after WIDTH shifts it holds the result LSB-aligned. diff is only written
    // on the final bit so partial results never show on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            w_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    w_sr <= {bit_d, w_sr[WIDTH-1:1]};
                    br   <= bit_bo;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        diff       <= {bit_d, w_sr[WIDTH-1:1]};
                        borrow_out <= bit_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) driven by directed vectors.
// Latency: expects done 9 cycles after accept and 10-cycle spacing when start is held.
// Backpressure: n/a.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    exp_t sbq[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done with diff=%0d borrow=%0d, required no done", diff, borrow_out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if ({diff, borrow_out} !== e) begin
                    n_bad++;
                    $display("FAIL result: got diff=%0d borrow=%0d, required diff=%0d borrow=%0d",
                             diff, borrow_out, e.d, e.bo);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] ed, input logic eb, input bit push);
        exp_t e;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        if (push) begin
            e.d  = ed;
            e.bo = eb;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; k = negedges advanced, bc = busy cycles seen.
    task automatic wait_done(output int k, output int bc);
        k  = 0;
        bc = 0;
        while (done !== 1'b1 && k < 30) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done after %0d cycles, required done", k);
        end
    endtask

    logic [7:0] va_t[4] = '{8'd10, 8'd3,   8'd255, 8'd128};
    logic [7:0] vb_t[4] = '{8'd3,  8'd10,  8'd255, 8'd1};
    logic [7:0] ed_t[4] = '{8'd7,  8'd249, 8'd0,   8'd127};
    logic       eb_t[4] = '{1'b0,  1'b1,   1'b0,   1'b0};

    initial begin
        int k, bc, dc0, prev_cyc;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_borrow", borrow_out, 0);
        rst = 1'b0;

        // Basic op with latency and busy-length checks
        issue(8'd100, 8'd37, 8'd63, 1'b0, 1'b1);
        wait_done(k, bc);
        chk("busy_cycles", bc, 8);
        chk("done_cycle_after_accept", k + 1, 9);
        @(negedge clk);
        chk("idle_after_done_busy", busy, 0);
        chk("done_one_cycle", done, 0);

        issue(8'd37, 8'd100, 8'hC1, 1'b1, 1'b1);
        wait_done(k, bc);
        @(negedge clk);
        issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1);
        wait_done(k, bc);
        @(negedge clk);
        issue(8'h55, 8'h55, 8'h00, 1'b0, 1'b1);
        wait_done(k, bc);
        @(negedge clk);

        // start during SHIFT must be ignored
        dc0 = done_cnt;
        issue(8'd200, 8'd50, 8'd150, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'd1;
        b     = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bc);
        repeat (15) @(negedge clk);
        chk("ignored_start_done_count", done_cnt - dc0, 1);
        chk("ignored_start_busy", busy, 0);
        chk("hold_diff", diff, 150);

        // Reset during SHIFT aborts with no done
        dc0 = done_cnt;
        issue(8'd9, 8'd3, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        issue(8'd9, 8'd3, 8'd6, 1'b0, 1'b1);
        wait_done(k, bc);
        @(negedge clk);

        // start held high: back-to-back ops, operands change after each accept
        @(negedge clk);
        a     = va_t[0];
        b     = vb_t[0];
        start = 1'b1;
        e.d   = ed_t[0];
        e.bo  = eb_t[0];
        sbq.push_back(e);
        @(negedge clk);
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i + 1 < 4) begin
                a    = va_t[i+1];
                b    = vb_t[i+1];
                e.d  = ed_t[i+1];
                e.bo = eb_t[i+1];
                sbq.push_back(e);
            end else begin
                start = 1'b0;
            end
            wait_done(k, bc);
            if (i > 0) chk("b2b_done_spacing", cyc - prev_cyc, 10);
            prev_cyc = cyc;
            repeat (2) @(negedge clk);
        end

        repeat (15) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
